// File: rtl/picomips_pkg.sv
// Shared types for the picoMips accumulator core: opcode and control-state encodings.
package picomips_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_LDI   = 4'd1,
    OP_LDS   = 4'd2,
    OP_LDR   = 4'd3,
    OP_STR   = 4'd4,
    OP_ADDI  = 4'd5,
    OP_ADDR  = 4'd6,
    OP_MULI  = 4'd7,
    OP_MULR  = 4'd8,
    OP_JMP   = 4'd9,
    OP_BZ    = 4'd10,
    OP_BNZ   = 4'd11,
    OP_WAITH = 4'd12,
    OP_WAITL = 4'd13,
    OP_HALT  = 4'd14,
    OP_RSVD  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/picomips_alu.sv
// Combinational next-accumulator logic: loads, signed add and Q1.(W-1) fractional multiply,
// with optional clamping to the signed range.
module picomips_alu
  import picomips_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] reg_val,
  input  logic [DATA_W-1:0] switches,
  output logic [DATA_W-1:0] acc_next
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  opcode_e                 opc;
  logic [DATA_W-1:0]       operand;
  logic [DATA_W:0]         sum;
  logic [2*DATA_W-1:0]     prod;
  logic [DATA_W-1:0]       add_res;
  logic [DATA_W-1:0]       mul_res;

  always_comb begin
    opc     = opcode_e'(op);
    operand = (opc == OP_ADDR || opc == OP_MULR) ? reg_val : imm;

    sum = {acc[DATA_W-1], acc} + {operand[DATA_W-1], operand};
    if (SATURATE && (sum[DATA_W] != sum[DATA_W-1])) begin
      add_res = sum[DATA_W] ? MAX_NEG : MAX_POS;
    end else begin
      add_res = sum[DATA_W-1:0];
    end

    // Sign-extended unsigned multiply yields the exact two's complement product in 2W bits.
    prod = {{DATA_W{acc[DATA_W-1]}}, acc} * {{DATA_W{operand[DATA_W-1]}}, operand};
    if (SATURATE && (prod[2*DATA_W-1:2*DATA_W-2] == 2'b01)) begin
      mul_res = MAX_POS;
    end else begin
      mul_res = prod[2*DATA_W-2:DATA_W-1];
    end

    case (opc)
      OP_LDI:            acc_next = imm;
      OP_LDS:            acc_next = switches;
      OP_LDR:            acc_next = reg_val;
      OP_ADDI, OP_ADDR:  acc_next = add_res;
      OP_MULI, OP_MULR:  acc_next = mul_res;
      default:           acc_next = acc;
    endcase
  end

endmodule

// File: rtl/picomips_core.sv
// Two-cycle (FETCH/EXEC) accumulator core with register file, branches, handshake waits and HALT.
module picomips_core
  import picomips_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned PC_W     = 5,
  parameter bit          SATURATE = 1'b1,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS),
  localparam int unsigned INSTR_W = OP_W + REG_AW + DATA_W
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic [DATA_W-1:0]  Switches,
  input  logic               Handshake,
  output logic [PC_W-1:0]    InstrAddr,
  input  logic [INSTR_W-1:0] Instr,
  output logic [DATA_W-1:0]  Acc,
  output logic               Stalled,
  output logic               Halted
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                halted_q, halted_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  opcode_e             op;
  logic [REG_AW-1:0]   rsel;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   reg_val;
  logic [DATA_W-1:0]   alu_acc;
  logic                wait_block;
  logic                take_jump;

  assign op      = opcode_e'(Instr[INSTR_W-1 -: OP_W]);
  assign rsel    = Instr[DATA_W +: REG_AW];
  assign imm     = Instr[DATA_W-1:0];
  assign reg_val = regs_q[rsel];

  picomips_alu #(
    .DATA_W   (DATA_W),
    .SATURATE (SATURATE)
  ) u_alu (
    .op       (Instr[INSTR_W-1 -: OP_W]),
    .acc      (acc_q),
    .imm      (imm),
    .reg_val  (reg_val),
    .switches (Switches),
    .acc_next (alu_acc)
  );

  always_comb begin
    wait_block = ((op == OP_WAITH) && !Handshake) || ((op == OP_WAITL) && Handshake);
    take_jump  = (op == OP_JMP) ||
                 ((op == OP_BZ)  && (acc_q == '0)) ||
                 ((op == OP_BNZ) && (acc_q != '0));
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    halted_d = halted_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    case (state_q)
      FETCH: state_d = EXEC;
      EXEC: begin
        if (op == OP_HALT) begin
          // PC stays on the HALT word so InstrAddr freezes there.
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (!wait_block) begin
          state_d = FETCH;
          acc_d   = alu_acc;
          pc_d    = take_jump ? imm[PC_W-1:0] : pc_q + PC_W'(1);
          if (op == OP_STR) regs_d[rsel] = acc_q;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      acc_q    <= '0;
      halted_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      halted_q <= halted_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign InstrAddr = pc_q;
  assign Acc       = acc_q;
  assign Halted    = halted_q;
  assign Stalled   = (state_q == EXEC) && wait_block;

endmodule

// File: tb/tb_picomips_core.sv
// Bench for picomips_core: instruction-level reference model checked every cycle, plus directed programs.
module tb_picomips_core;

  localparam bit SAT = 1'b1;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        Handshake = 1'b0;
  logic [7:0]  Switches = 8'h00;
  logic [4:0]  InstrAddr;
  logic [13:0] Instr;
  logic [7:0]  Acc;
  logic        Stalled;
  logic        Halted;

  logic [13:0] mem [32];
  logic [13:0] prog [$];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // reference model state
  int m_pc = 0;
  int m_acc = 0;
  int m_regs [4] = '{0, 0, 0, 0};
  bit m_exec = 1'b0;
  bit m_halt = 1'b0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) Instr <= mem[InstrAddr];

  picomips_core #(
    .DATA_W   (8),
    .NUM_REGS (4),
    .PC_W     (5),
    .SATURATE (SAT)
  ) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .Switches  (Switches),
    .Handshake (Handshake),
    .InstrAddr (InstrAddr),
    .Instr     (Instr),
    .Acc       (Acc),
    .Stalled   (Stalled),
    .Halted    (Halted)
  );

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int fit(input int v);
    int r;
    r = v;
    if (SAT && r > 127)  r = 127;
    if (SAT && r < -128) r = -128;
    return r & 255;
  endfunction

  function automatic int add_f(input int a, input int b);
    return fit(sx(a) + sx(b));
  endfunction

  function automatic int mul_f(input int a, input int b);
    int p;
    p = sx(a) * sx(b);
    return fit(p >>> 7);
  endfunction

  always @(posedge Clock) begin
    int op, r, imm, nxt;
    bit done;
    if (!nReset) begin
      m_pc = 0; m_acc = 0; m_exec = 1'b0; m_halt = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
    end else if (m_halt) begin
    end else if (!m_exec) begin
      m_exec = 1'b1;
    end else begin
      op   = int'(mem[m_pc][13:10]);
      r    = int'(mem[m_pc][9:8]);
      imm  = int'(mem[m_pc][7:0]);
      nxt  = (m_pc + 1) % 32;
      done = 1'b1;
      case (op)
        1:  m_acc = imm;
        2:  m_acc = int'(Switches);
        3:  m_acc = m_regs[r];
        4:  m_regs[r] = m_acc;
        5:  m_acc = add_f(m_acc, imm);
        6:  m_acc = add_f(m_acc, m_regs[r]);
        7:  m_acc = mul_f(m_acc, imm);
        8:  m_acc = mul_f(m_acc, m_regs[r]);
        9:  nxt = imm % 32;
        10: if (m_acc == 0) nxt = imm % 32;
        11: if (m_acc != 0) nxt = imm % 32;
        12: if (!Handshake) done = 1'b0;
        13: if (Handshake) done = 1'b0;
        14: begin m_halt = 1'b1; done = 1'b0; end
        default: ;
      endcase
      if (done) begin
        m_pc = nxt;
        m_exec = 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    int op;
    bit exp_stall;
    if (chk_en) begin
      op = int'(mem[m_pc][13:10]);
      exp_stall = m_exec && !m_halt && ((op == 12 && !Handshake) || (op == 13 && Handshake));
      check("instr_addr", 32'(InstrAddr), 32'(m_pc));
      check("acc", 32'(Acc), 32'(m_acc));
      check("halted", 32'(Halted), 32'(m_halt));
      check("stalled", 32'(Stalled), 32'(exp_stall));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic p(input logic [3:0] op, input logic [1:0] r, input logic [7:0] imm);
    prog.push_back({op, r, imm});
  endtask

  task automatic load_prog();
    nReset = 1'b0;
    tick(1);
    for (int i = 0; i < 32; i++) mem[i] = {4'd14, 10'd0};
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
  endtask

  task automatic wait_halt(input string nm, input int max);
    int n;
    n = 0;
    while (!Halted && n < max) begin
      tick(1);
      n++;
    end
    if (!Halted) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: Halted=%0b, expected 1 within %0d cycles", nm, Halted, max);
    end
  endtask

  task automatic run_directed(input string nm, input logic [7:0] exp);
    load_prog();
    tick(2);
    nReset = 1'b1;
    wait_halt(nm, 300);
    check(nm, 32'(Acc), 32'(exp));
    check({nm, "_model"}, 32'(m_acc), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    tick(2);
    chk_en = 1'b1;

    // fractional multiply
    prog.delete(); p(1, 0, 8'h40); p(7, 0, 8'h40); p(14, 0, 0);
    run_directed("mul_pos", 8'h20);
    prog.delete(); p(1, 0, 8'hC0); p(7, 0, 8'h40); p(14, 0, 0);
    run_directed("mul_neg", 8'hE0);

    // saturation / wrap boundaries
    prog.delete(); p(1, 0, 8'h80); p(7, 0, 8'h80); p(14, 0, 0);
    run_directed("mul_m1m1", SAT ? 8'h7F : 8'h80);
    prog.delete(); p(1, 0, 8'h70); p(5, 0, 8'h20); p(14, 0, 0);
    run_directed("add_ovf_pos", SAT ? 8'h7F : 8'h90);
    prog.delete(); p(1, 0, 8'h90); p(5, 0, 8'hF0); p(14, 0, 0);
    run_directed("add_ovf_neg", 8'h80);

    // register file round trip, MULR/ADDR via registers
    prog.delete(); p(1, 0, 8'h33); p(4, 2, 0); p(1, 0, 8'h00); p(3, 2, 0); p(14, 0, 0);
    run_directed("str_ldr", 8'h33);
    prog.delete(); p(1, 0, 8'h40); p(4, 1, 0); p(8, 1, 0); p(6, 1, 0); p(14, 0, 0);
    run_directed("mulr_addr", 8'h60);

    // branches
    prog.delete(); p(1, 0, 0); p(10, 0, 4); p(1, 0, 8'h11); p(14, 0, 0); p(1, 0, 8'h22); p(14, 0, 0);
    run_directed("bz_taken", 8'h22);
    prog.delete(); p(1, 0, 1); p(10, 0, 4); p(1, 0, 8'h11); p(14, 0, 0); p(1, 0, 8'h22); p(14, 0, 0);
    run_directed("bz_not_taken", 8'h11);

    // JMP 31 to a NOP, then PC wraps to 0 where BNZ now escapes
    prog.delete(); p(11, 0, 3); p(1, 0, 8'h07); p(9, 0, 31); p(14, 0, 0);
    load_prog();
    mem[31] = '0;
    tick(2);
    nReset = 1'b1;
    wait_halt("jmp_wrap", 300);
    check("jmp_wrap", 32'(Acc), 32'h07);
    check("jmp_wrap_addr", 32'(InstrAddr), 32'd3);

    // halted core stays frozen; reset pulse clears it
    tick(10);
    check("halt_frozen_acc", 32'(Acc), 32'h07);
    check("halt_frozen_addr", 32'(InstrAddr), 32'd3);
    nReset = 1'b0;
    tick(1);
    check("halt_reset", 32'(Halted), 32'd0);
    check("halt_reset_addr", 32'(InstrAddr), 32'd0);

    // handshake waits and LDS
    prog.delete(); p(12, 0, 0); p(13, 0, 0); p(2, 0, 0); p(14, 0, 0);
    load_prog();
    Handshake = 1'b0;
    Switches = 8'h5A;
    tick(2);
    nReset = 1'b1;
    tick(7);
    check("waith_stall", 32'(Stalled), 32'd1);
    check("waith_addr", 32'(InstrAddr), 32'd0);
    Handshake = 1'b1;
    tick(3);
    check("waitl_stall", 32'(Stalled), 32'd1);
    check("waitl_addr", 32'(InstrAddr), 32'd1);
    Handshake = 1'b0;
    wait_halt("lds", 50);
    check("lds", 32'(Acc), 32'h5A);

    // reset mid-program
    prog.delete(); p(1, 0, 1); p(5, 0, 1); p(9, 0, 1);
    load_prog();
    tick(2);
    nReset = 1'b1;
    tick(20);
    nReset = 1'b0;
    tick(3);
    check("rst_acc", 32'(Acc), 32'h00);
    check("rst_addr", 32'(InstrAddr), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    nReset = 1'b1;
    tick(1);
    check("rst_first_fetch", 32'(InstrAddr), 32'd0);
    tick(6);

    // randomized programs and inputs against the model
    for (int t = 0; t < 20; t++) begin
      prog.delete();
      for (int i = 0; i < 32; i++) begin
        logic [3:0] rop;
        rop = 4'($urandom_range(0, 15));
        if (rop == 4'd14 && $urandom_range(0, 3) != 0) rop = 4'd5;
        p(rop, 2'($urandom_range(0, 3)), 8'($urandom));
      end
      load_prog();
      tick(2);
      nReset = 1'b1;
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 3) == 0) Handshake = ~Handshake;
        Switches = 8'($urandom);
        tick(1);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
